non_restoring_division_controller: RTL and testbench

- FSM that sequences the 16-bit non-restoring division datapath.
- Sits directly upstream of the datapath and drives all of its control inputs: select_A, select_Q, ld_A, ld_Q, both shift enables and count_enable.
- Provides the start/busy/done handshake to the requester.
- Detects divide-by-zero before any iteration starts.

---
 rtl/nrd_pkg.sv | 63 ++++++
 rtl/nrd_iter_counter.sv | 30 +++
 rtl/non_restoring_division_controller.sv | 96 +++++++++
 tb/tb_non_restoring_division_controller.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/nrd_pkg.sv
// rtl/nrd_pkg.sv - shared types, constants and control decode for the non-restoring division controller
// Optional feature macro: NRD_CTRL_DONE_HOLD_EN
package nrd_pkg;

   localparam int NRD_WIDTH = 16;
   localparam int NRD_CNT_W = $clog2(NRD_WIDTH);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_SHIFT  = 3'd2,
      ST_UPDATE = 3'd3,
      ST_FINISH = 3'd4,
      ST_DONE   = 3'd5
   } nrd_state_t;

   typedef struct packed {
      logic select_a;
      logic select_q;
      logic ld_a;
      logic ld_q;
      logic shift_a;
      logic shift_q;
      logic count_en;
      logic busy;
   } nrd_ctrl_t;

   // Moore decode of the datapath controls for a given state
   function automatic nrd_ctrl_t nrd_decode(input nrd_state_t st);
      nrd_ctrl_t c;
      c = '0;
      case (st)
         ST_LOAD: begin
            c.ld_a = 1'b1;
            c.ld_q = 1'b1;
            c.busy = 1'b1;
         end
         ST_SHIFT: begin
            c.shift_a = 1'b1;
            c.shift_q = 1'b1;
            c.busy    = 1'b1;
         end
         ST_UPDATE: begin
            c.select_a = 1'b1;
            c.select_q = 1'b1;
            c.ld_a     = 1'b1;
            c.ld_q     = 1'b1;
            c.count_en = 1'b1;
            c.busy     = 1'b1;
         end
         ST_FINISH: c.busy = 1'b1;
`ifdef NRD_CTRL_DONE_HOLD_EN
         // requester owns the bus again while the result is being held
         ST_DONE: c.busy = 1'b0;
`else
         ST_DONE: c.busy = 1'b1;
`endif
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/nrd_iter_counter.sv
// rtl/nrd_iter_counter.sv - iteration counter with clear, increment and last-iteration flag
module nrd_iter_counter
   import nrd_pkg::*;
#(
   parameter int WIDTH = NRD_WIDTH,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_last
);

   logic [CNT_W-1:0] r_count;

   // count iterations; wraps naturally after the final increment
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_inc) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_last = (r_count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/non_restoring_division_controller.sv
// rtl/non_restoring_division_controller.sv - FSM sequencing the non-restoring division datapath (macro NRD_CTRL_DONE_HOLD_EN)
module non_restoring_division_controller
   import nrd_pkg::*;
#(
   parameter int WIDTH = NRD_WIDTH,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] divisor,
   output logic             select_A,
   output logic             select_Q,
   output logic             ld_A,
   output logic             ld_Q,
   output logic             shift_left_enable_a,
   output logic             shift_left_enable_q,
   output logic             count_enable,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   nrd_state_t r_state;
   nrd_state_t w_next;
   nrd_ctrl_t  r_ctrl;
   logic       r_done;
   logic       r_dbz;
   logic       w_accept;
   logic       w_dbz_next;
   logic       w_last;

   nrd_iter_counter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_iter_counter (
      .i_clk   (clk),
      .i_rst_n (rst),
      .i_clr   (r_state == ST_LOAD),
      .i_inc   (r_state == ST_UPDATE),
      .o_last  (w_last)
   );

   // next-state logic; a zero divisor skips the iterations entirely
   always_comb begin
      w_next     = r_state;
      w_accept   = 1'b0;
      w_dbz_next = 1'b0;
      case (r_state)
         ST_IDLE:   w_accept = start;
         ST_LOAD:   w_next   = ST_SHIFT;
         ST_SHIFT:  w_next   = ST_UPDATE;
         ST_UPDATE: w_next   = w_last ? ST_FINISH : ST_SHIFT;
         ST_FINISH: w_next   = ST_DONE;
`ifdef NRD_CTRL_DONE_HOLD_EN
         ST_DONE:   w_accept = start;
`else
         ST_DONE:   w_next   = ST_IDLE;
`endif
         default:   w_next   = ST_IDLE;
      endcase
      if (w_accept) begin
         w_next     = (divisor == '0) ? ST_DONE : ST_LOAD;
         w_dbz_next = (divisor == '0);
      end else if (r_state == ST_DONE && w_next == ST_DONE) begin
         w_dbz_next = r_dbz;
      end
   end

   // state register with outputs registered from the decode of the next state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_ctrl  <= '0;
         r_done  <= 1'b0;
         r_dbz   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_ctrl  <= nrd_decode(w_next);
         r_done  <= (w_next == ST_DONE);
         r_dbz   <= w_dbz_next;
      end
   end

   assign select_A            = r_ctrl.select_a;
   assign select_Q            = r_ctrl.select_q;
   assign ld_A                = r_ctrl.ld_a;
   assign ld_Q                = r_ctrl.ld_q;
   assign shift_left_enable_a = r_ctrl.shift_a;
   assign shift_left_enable_q = r_ctrl.shift_q;
   assign count_enable        = r_ctrl.count_en;
   assign busy                = r_ctrl.busy;
   assign done                = r_done;
   assign div_by_zero         = r_dbz;

endmodule

// File: tb/tb_non_restoring_division_controller.sv
// tb/tb_non_restoring_division_controller.sv - scoreboard bench for the non-restoring division controller
module tb_non_restoring_division_controller;

   localparam int W = 16;
`ifdef NRD_CTRL_DONE_HOLD_EN
   localparam int NZ_BUSY = 34;
`else
   localparam int NZ_BUSY = 35;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] divisor = '0;
   logic [W-1:0] dividend = '0;
   logic select_A, select_Q, ld_A, ld_Q, sh_a, sh_q, count_enable, busy, done, div_by_zero;

   non_restoring_division_controller dut (
      .clk                 (clk),
      .rst                 (rst),
      .start               (start),
      .divisor             (divisor),
      .select_A            (select_A),
      .select_Q            (select_Q),
      .ld_A                (ld_A),
      .ld_Q                (ld_Q),
      .shift_left_enable_a (sh_a),
      .shift_left_enable_q (sh_q),
      .count_enable        (count_enable),
      .busy                (busy),
      .done                (done),
      .div_by_zero         (div_by_zero)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // behavioural non-restoring datapath driven by the controller outputs
   logic signed [W:0] m_a;
   logic [W-1:0]      m_q;
   logic              m_sgn;
   logic signed [W:0] m_sum;
   assign m_sum = m_sgn ? (m_a + $signed({1'b0, divisor})) : (m_a - $signed({1'b0, divisor}));

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_a   <= '0;
         m_q   <= '0;
         m_sgn <= 1'b0;
      end else begin
         if (ld_A && !select_A) m_a <= '0;
         if (ld_Q && !select_Q) m_q <= dividend;
         if (sh_a && sh_q) begin
            m_sgn <= m_a[W];
            m_a   <= {m_a[W-1:0], m_q[W-1]};
            m_q   <= {m_q[W-2:0], 1'b0};
         end
         if (ld_A && select_A) m_a <= m_sum;
         if (ld_Q && select_Q) m_q <= {m_q[W-1:1], ~m_sum[W]};
      end
   end

   typedef struct {
      int           exp_done;
      logic [W-1:0] quot;
      logic [W-1:0] rem;
      logic         dbz;
      int           ce;
      int           ld;
      int           sh;
      int           bz;
   } exp_t;
   exp_t sb[$];

   // monitor: tally control pulses and check each result against the scoreboard
   int   n_ce = 0, n_ld = 0, n_sh = 0, n_bz = 0;
   logic prev_done = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      logic signed [W:0] rfix;
      if (!rst) begin
         n_ce = 0; n_ld = 0; n_sh = 0; n_bz = 0;
         prev_done = 1'b0;
      end else begin
         n_ce += int'(count_enable);
         n_ld += int'(ld_A);
         n_sh += int'(sh_a);
         n_bz += int'(busy);
         if (done && !prev_done) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("done_cycle", cyc, e.exp_done);
               chk("div_by_zero", int'(div_by_zero), int'(e.dbz));
               chk("count_enable_pulses", n_ce, e.ce);
               chk("ld_A_pulses", n_ld, e.ld);
               chk("shift_pulses", n_sh, e.sh);
               chk("busy_cycles", n_bz, e.bz);
               if (!e.dbz) begin
                  rfix = m_a[W] ? (m_a + $signed({1'b0, divisor})) : m_a;
                  chk("quotient", int'(m_q), int'(e.quot));
                  chk("remainder", int'(rfix[W-1:0]), int'(e.rem));
               end
            end
            n_ce = 0; n_ld = 0; n_sh = 0; n_bz = 0;
         end
         prev_done = done;
      end
   end

   task automatic push_exp(input int acc, input int extra, input logic [W-1:0] dv,
                           input logic [W-1:0] q, input logic [W-1:0] r);
      exp_t e;
      if (dv == '0) begin
         e = '{acc, '0, '0, 1'b1, 0, 0, 0, (NZ_BUSY == 35) ? 1 : 0};
      end else begin
         e = '{acc + 34 + extra, q, r, 1'b0, W, W + 1, W, NZ_BUSY};
      end
      sb.push_back(e);
   endtask

   // drive one start pulse at a negedge; the next posedge is the accept edge
   task automatic issue(input logic [W-1:0] dd, input logic [W-1:0] dv,
                        input logic [W-1:0] q, input logic [W-1:0] r);
      dividend = dd;
      divisor  = dv;
      start    = 1'b1;
      push_exp(cyc + 1, 0, dv, q, r);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         chk({name, "_timeout"}, sb.size(), 0);
         sb.delete();
      end
      @(negedge clk);
   endtask

   task automatic chk_quiet(input string name);
      chk(name, int'({select_A, select_Q, ld_A, ld_Q, sh_a, sh_q, count_enable, busy, done, div_by_zero}), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   initial begin
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk_quiet("reset_outputs");
      rst = 1'b1;
      @(negedge clk);
      chk_quiet("idle_after_reset");

`ifdef NRD_CTRL_DONE_HOLD_EN
      issue(16'd100, 16'd7, 16'd14, 16'd2);
      drain("hold_op1");
      for (int i = 0; i < 10; i++) begin
         chk("hold_done", int'(done), 1);
         chk("hold_busy", int'(busy), 0);
         @(negedge clk);
      end
      issue(16'd255, 16'd16, 16'd15, 16'd15);
      chk("hold_exit_done", int'(done), 0);
      chk("hold_exit_load", int'(ld_A & busy), 1);
      drain("hold_op2");
`else
      // basic operation
      issue(16'd100, 16'd7, 16'd14, 16'd2);
      drain("op_100_7");

      // divide by zero
      issue(16'd5, 16'd0, 16'd0, 16'd0);
      drain("op_div0");

      // start pulsed again mid-operation is ignored
      issue(16'd100, 16'd7, 16'd14, 16'd2);
      repeat (10) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drain("op_ignored_start");
      chk("no_extra_op", int'(busy), 0);

      // asynchronous reset mid-operation discards the result
      issue(16'd100, 16'd7, 16'd14, 16'd2);
      repeat (16) @(negedge clk);
      #2 rst = 1'b0;
      #1 chk_quiet("async_reset_outputs");
      sb.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_quiet("idle_after_abort");
      issue(16'd255, 16'd16, 16'd15, 16'd15);
      drain("op_255_16");

      // start held across two operations
      dividend = 16'd50;
      divisor  = 16'd3;
      start    = 1'b1;
      push_exp(cyc + 1, 0, 16'd3, 16'd16, 16'd2);
      push_exp(cyc + 1, 36, 16'd3, 16'd16, 16'd2);
      for (int i = 0; i < 100 && sb.size() > 1; i++) @(negedge clk);
      for (int i = 0; i < 5 && !busy; i++) @(negedge clk);
      start = 1'b0;
      drain("op_held_start");
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
